// File: rtl/mvm_pkg.sv
// Shared types and sizing helpers for the matrix-vector multiplier driver.
package mvm_pkg;

    typedef enum logic [2:0] {
        S_LOAD,
        S_START,
        S_STREAM,
        S_WAIT,
        S_CAPTURE,
        S_DRAIN
    } state_t;

    // Words per transaction: M*M matrix entries followed by M vector entries.
    function automatic int unsigned txn_words(input int unsigned m);
        return m * m + m;
    endfunction

    function automatic int unsigned buf_idx_width(input int unsigned m);
        return (txn_words(m) > 1) ? $clog2(txn_words(m)) : 1;
    endfunction

    function automatic int unsigned res_idx_width(input int unsigned m);
        return (m > 1) ? $clog2(m) : 1;
    endfunction

endpackage

// File: rtl/mvm_operand_buffer.sv
// Transaction operand store: one write port, asynchronous read port.
module mvm_operand_buffer #(
    parameter int unsigned DEPTH = 20,
    parameter int unsigned WIDTH = 8,
    parameter int unsigned AW    = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/mvm_driver.sv
// Buffers one operand transaction, replays it into the multiplier and
// returns the captured results on a valid/ready stream.
module mvm_driver
    import mvm_pkg::*;
#(
    parameter int unsigned MAT_SCALE    = 4,
    parameter int unsigned INPUT_WIDTH  = 8,
    parameter int unsigned OUTPUT_WIDTH = 16,
    parameter int unsigned TIMEOUT      = 64
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [INPUT_WIDTH-1:0]  in_data,
    output logic                    mvm_start,
    output logic [INPUT_WIDTH-1:0]  mvm_data_in,
    input  logic                    mvm_done,
    input  logic [OUTPUT_WIDTH-1:0] mvm_data_out,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [OUTPUT_WIDTH-1:0] out_data,
    output logic                    out_last,
    output logic                    busy,
    output logic                    timeout_err
);

    localparam int unsigned N  = txn_words(MAT_SCALE);
    localparam int unsigned BW = buf_idx_width(MAT_SCALE);
    localparam int unsigned RW = res_idx_width(MAT_SCALE);
    localparam int unsigned WW = $clog2(TIMEOUT + 1);

    localparam logic [BW-1:0] LAST_WORD = BW'(N - 1);
    localparam logic [RW-1:0] LAST_RES  = RW'(MAT_SCALE - 1);
    localparam logic [WW-1:0] WD_LIMIT  = WW'(TIMEOUT - 1);

    state_t                  state;
    logic [BW-1:0]           cnt;
    logic [BW-1:0]           k;
    logic [RW-1:0]           j;
    logic [RW-1:0]           j_nxt;
    logic [WW-1:0]           wd;
    logic [OUTPUT_WIDTH-1:0] y [MAT_SCALE];
    logic                    we;
    logic [BW-1:0]           raddr;
    logic [INPUT_WIDTH-1:0]  rdata;

    assign we    = (state == S_LOAD) && in_valid && in_ready;
    assign j_nxt = j + RW'(1);
    // Read one word ahead so mvm_data_in can be registered without a gap.
    assign raddr = ((state == S_STREAM) && (k != LAST_WORD)) ? k + BW'(1) : '0;

    mvm_operand_buffer #(
        .DEPTH (N),
        .WIDTH (INPUT_WIDTH),
        .AW    (BW)
    ) u_buf (
        .clk   (clk),
        .reset (reset),
        .we    (we),
        .waddr (cnt),
        .wdata (in_data),
        .raddr (raddr),
        .rdata (rdata)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int unsigned i = 0; i < MAT_SCALE; i++) y[i] <= '0;
        end else if (state == S_CAPTURE) begin
            y[j] <= mvm_data_out;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= S_LOAD;
            cnt         <= '0;
            k           <= '0;
            j           <= '0;
            wd          <= '0;
            in_ready    <= 1'b1;
            busy        <= 1'b0;
            mvm_start   <= 1'b0;
            mvm_data_in <= '0;
            out_valid   <= 1'b0;
            out_data    <= '0;
            out_last    <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            case (state)
                S_LOAD: begin
                    if (we) begin
                        if (cnt == LAST_WORD) begin
                            cnt       <= '0;
                            in_ready  <= 1'b0;
                            busy      <= 1'b1;
                            mvm_start <= 1'b1;
                            state     <= S_START;
                        end else begin
                            cnt <= cnt + BW'(1);
                        end
                    end
                end
                S_START: begin
                    mvm_start   <= 1'b0;
                    mvm_data_in <= rdata;
                    k           <= '0;
                    state       <= S_STREAM;
                end
                S_STREAM: begin
                    if (k == LAST_WORD) begin
                        mvm_data_in <= '0;
                        wd          <= '0;
                        state       <= S_WAIT;
                    end else begin
                        mvm_data_in <= rdata;
                        k           <= k + BW'(1);
                    end
                end
                S_WAIT: begin
                    if (mvm_done) begin
                        j     <= '0;
                        wd    <= '0;
                        state <= S_CAPTURE;
                    end else if (wd == WD_LIMIT) begin
                        timeout_err <= 1'b1;
                        cnt         <= '0;
                        wd          <= '0;
                        in_ready    <= 1'b1;
                        busy        <= 1'b0;
                        state       <= S_LOAD;
                    end else begin
                        wd <= wd + WW'(1);
                    end
                end
                S_CAPTURE: begin
                    if (j == LAST_RES) begin
                        // j is still zero here only when a single result exists.
                        out_data  <= (j == '0) ? mvm_data_out : y[0];
                        out_last  <= (j == '0);
                        out_valid <= 1'b1;
                        j         <= '0;
                        state     <= S_DRAIN;
                    end else begin
                        j <= j_nxt;
                    end
                end
                S_DRAIN: begin
                    if (out_ready) begin
                        if (j == LAST_RES) begin
                            out_valid <= 1'b0;
                            out_data  <= '0;
                            out_last  <= 1'b0;
                            cnt       <= '0;
                            j         <= '0;
                            in_ready  <= 1'b1;
                            busy      <= 1'b0;
                            state     <= S_LOAD;
                        end else begin
                            out_data <= y[j_nxt];
                            out_last <= (j_nxt == LAST_RES);
                            j        <= j_nxt;
                        end
                    end
                end
                default: state <= S_LOAD;
            endcase
        end
    end

endmodule
